branch_predictor: RTL and testbench

- Parametrised, tagged branch target buffer combined with a table of saturating direction counters.
- Successor to the untagged, single-bit-valid BTB in the 7-stage MIPS core.
- Lookup port is driven from IF with the fetch PC. Prediction is registered and is used one cycle later, in IG.
- Update port is driven from WA with the resolved branch outcome.
- Contains a reset-time clear sequencer, so no multi-cycle external init is needed.

---
 rtl/branch_predictor_if.sv | 27 ++
 rtl/branch_predictor.sv | 164 ++++++++++++++++
 tb/tb_branch_predictor.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup, update and status signals of the branch predictor.
// master = fetch/writeback side of the core, slave = predictor.
interface branch_predictor_if;
    logic        lk_en;
    logic [31:0] lk_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_tgt;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_is_branch;
    logic        up_taken;
    logic [31:0] up_tgt;
    logic        busy;

    modport master (
        output lk_en, lk_pc,
        output up_valid, up_pc, up_is_branch, up_taken, up_tgt,
        input  pred_hit, pred_taken, pred_tgt, busy
    );

    modport slave (
        input  lk_en, lk_pc,
        input  up_valid, up_pc, up_is_branch, up_taken, up_tgt,
        output pred_hit, pred_taken, pred_tgt, busy
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: tagged BTB with saturating direction counters and a clear sweep.
// Define BRANCH_PREDICTOR_GSHARE_EN to index the counters by pc XOR global history.
module branch_predictor #(
    parameter int IDX_W = 10,
    parameter int TAG_W = 8,
    parameter int CNT_W = 2,
    parameter int GHR_W = 8
) (
    input logic clk,
    input logic rst,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] WT = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] WT_M1 = WT - CNT_W'(1);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic             pred_hit_q;
    logic             pred_taken_q;
    logic [31:0]      pred_tgt_q;
    logic             pred_hit_d;
    logic             pred_taken_d;
    logic [31:0]      pred_tgt_d;

    logic             valid_q [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [31:0]      tgt_q   [DEPTH];
    logic [CNT_W-1:0] cnt_q   [DEPTH];

    logic             run;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] lk_cidx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [IDX_W-1:0] up_cidx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_acc;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_dec;
    logic             unused_pc;

    assign run    = (state_q == RUN);
    assign lk_idx = bp.lk_pc[2 +: IDX_W];
    assign lk_tag = bp.lk_pc[2+IDX_W +: TAG_W];
    assign up_idx = bp.up_pc[2 +: IDX_W];
    assign up_tag = bp.up_pc[2+IDX_W +: TAG_W];

    // Only the index and tag fields of either PC feed the tables.
    assign unused_pc = ^{bp.lk_pc, bp.up_pc};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    assign lk_cidx = lk_idx ^ IDX_W'(ghr_q);
    assign up_cidx = up_idx ^ IDX_W'(ghr_q);
`else
    assign lk_cidx = lk_idx;
    assign up_cidx = up_idx;
`endif

    always_comb begin
        lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_hit_d   = run && lk_hit;
        pred_taken_d = pred_hit_d && cnt_q[lk_cidx][CNT_W-1];
        pred_tgt_d   = bp.lk_pc + 32'd4;
        if (pred_taken_d) begin
            pred_tgt_d = tgt_q[lk_idx];
        end
    end

    always_comb begin
        up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_acc  = run && bp.up_valid;
        up_cnt  = cnt_q[up_cidx];
        cnt_inc = up_cnt;
        cnt_dec = up_cnt;
        if (up_cnt != CMAX) begin
            cnt_inc = up_cnt + CNT_W'(1);
        end
        if (up_cnt != '0) begin
            cnt_dec = up_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            pred_hit_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_tgt_q   <= '0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            ghr_q        <= '0;
`endif
        end else begin
            if (bp.lk_en) begin
                pred_hit_q   <= pred_hit_d;
                pred_taken_q <= pred_taken_d;
                pred_tgt_q   <= pred_tgt_d;
            end
            unique case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + IDX_W'(1);
                    if (clr_idx_q == '1) begin
                        state_q <= RUN;
                    end
`ifdef BRANCH_PREDICTOR_GSHARE_EN
                    ghr_q <= '0;
`endif
                end
                RUN: begin
`ifdef BRANCH_PREDICTOR_GSHARE_EN
                    // History is non-speculative: only resolved branches shift in.
                    if (up_acc && bp.up_is_branch) begin
                        ghr_q <= (ghr_q << 1) | GHR_W'(bp.up_taken);
                    end
`endif
                end
            endcase
        end
    end

    // Tables carry no reset; the sweep invalidates one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                valid_q[clr_idx_q] <= 1'b0;
                cnt_q[clr_idx_q]   <= WT_M1;
            end else if (up_acc) begin
                unique case (1'b1)
                    bp.up_is_branch && up_hit: begin
                        cnt_q[up_cidx] <= bp.up_taken ? cnt_inc : cnt_dec;
                        if (bp.up_taken) begin
                            tgt_q[up_idx] <= bp.up_tgt;
                        end
                    end
                    bp.up_is_branch && !up_hit && bp.up_taken: begin
                        valid_q[up_idx] <= 1'b1;
                        tag_q[up_idx]   <= up_tag;
                        tgt_q[up_idx]   <= bp.up_tgt;
                        cnt_q[up_cidx]  <= WT;
                    end
                    !bp.up_is_branch && up_hit: begin
                        valid_q[up_idx] <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bp.pred_hit   = pred_hit_q;
    assign bp.pred_taken = pred_taken_q;
    assign bp.pred_tgt   = pred_tgt_q;
    assign bp.busy       = !run;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of clear sweep, counters, aliasing and hazards.
// Small geometry: IDX_W=4, TAG_W=8, CNT_W=2.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    branch_predictor_if bp ();

    branch_predictor #(
        .IDX_W(4),
        .TAG_W(8),
        .CNT_W(2),
        .GHR_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic br,
                             input logic tk, input logic [31:0] tgt);
        bp.up_valid     = 1'b1;
        bp.up_pc        = pc;
        bp.up_is_branch = br;
        bp.up_taken     = tk;
        bp.up_tgt       = tgt;
        cyc();
        bp.up_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        bp.lk_en = 1'b1;
        bp.lk_pc = pc;
        cyc();
        bp.lk_en = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        bp.lk_en = 1'b1;
        bp.lk_pc = 32'h40;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total_cnt++;
        if (bp.pred_hit !== 1'b0) $display("FAIL rst_hit: got %b want 0", bp.pred_hit);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_taken !== 1'b0) $display("FAIL rst_taken: got %b want 0", bp.pred_taken);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h0) $display("FAIL rst_tgt: got %h want 0", bp.pred_tgt);
        else pass_cnt++;
        total_cnt++;
        if (bp.busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", bp.busy);
        else pass_cnt++;
        n = 0;
        bad = 0;
        while (bp.busy === 1'b1 && n < 40) begin
            n++;
            if (n > 1 && (bp.pred_hit !== 1'b0 || bp.pred_tgt !== 32'h44)) bad++;
            cyc();
        end
        total_cnt++;
        if (n != 16) $display("FAIL clear_len: got %0d want 16", n);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL clear_lookup: got %0d bad samples want 0", bad);
        else pass_cnt++;
        cyc();
        bp.lk_en = 1'b0;
        total_cnt++;
        if (bp.pred_hit !== 1'b0) $display("FAIL post_clear_hit: got %b want 0", bp.pred_hit);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h44) $display("FAIL post_clear_tgt: got %h want 44", bp.pred_tgt);
        else pass_cnt++;
    endtask

    task automatic test_alloc();
        do_update(32'h100, 1'b1, 1'b1, 32'h200);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_hit !== 1'b1) $display("FAIL alloc_hit: got %b want 1", bp.pred_hit);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_taken !== 1'b1) $display("FAIL alloc_taken: got %b want 1", bp.pred_taken);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h200) $display("FAIL alloc_tgt: got %h want 200", bp.pred_tgt);
        else pass_cnt++;
    endtask

    task automatic test_counter();
        // counter 2 -> 1 -> 0 -> 0
        for (int i = 0; i < 3; i++) do_update(32'h100, 1'b1, 1'b0, 32'h0);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_hit !== 1'b1) $display("FAIL nt_hit: got %b want 1", bp.pred_hit);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_taken !== 1'b0) $display("FAIL nt_taken: got %b want 0", bp.pred_taken);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h104) $display("FAIL nt_tgt: got %h want 104", bp.pred_tgt);
        else pass_cnt++;
        // fourth not-taken stays at 0; one taken gives 1 (not 0 after a wrap to 3)
        do_update(32'h100, 1'b1, 1'b0, 32'h0);
        do_update(32'h100, 1'b1, 1'b1, 32'h200);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_taken !== 1'b0) $display("FAIL sat_low: got %b want 0", bp.pred_taken);
        else pass_cnt++;
        // 1 -> 2 -> 3 -> 3, target follows the latest taken update
        for (int i = 0; i < 3; i++) do_update(32'h100, 1'b1, 1'b1, 32'h300);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_taken !== 1'b1) $display("FAIL sat_high: got %b want 1", bp.pred_taken);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h300) $display("FAIL tgt_upd: got %h want 300", bp.pred_tgt);
        else pass_cnt++;
        do_update(32'h100, 1'b1, 1'b0, 32'h0);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_taken !== 1'b1) $display("FAIL dec_from3: got %b want 1", bp.pred_taken);
        else pass_cnt++;
        do_update(32'h100, 1'b1, 1'b0, 32'h0);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_taken !== 1'b0) $display("FAIL dec_from2: got %b want 0", bp.pred_taken);
        else pass_cnt++;
    endtask

    task automatic test_alias();
        do_update(32'h100, 1'b0, 1'b0, 32'h0);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_hit !== 1'b0) $display("FAIL purge_hit: got %b want 0", bp.pred_hit);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h104) $display("FAIL purge_tgt: got %h want 104", bp.pred_tgt);
        else pass_cnt++;
        do_update(32'h100, 1'b1, 1'b1, 32'h200);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_hit !== 1'b1) $display("FAIL realloc_hit: got %b want 1", bp.pred_hit);
        else pass_cnt++;
        do_update(32'h1100, 1'b1, 1'b1, 32'h500);
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_hit !== 1'b0) $display("FAIL evicted_hit: got %b want 0", bp.pred_hit);
        else pass_cnt++;
        do_lookup(32'h1100);
        total_cnt++;
        if (bp.pred_hit !== 1'b1) $display("FAIL alias_hit: got %b want 1", bp.pred_hit);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h500) $display("FAIL alias_tgt: got %h want 500", bp.pred_tgt);
        else pass_cnt++;
        do_update(32'h100, 1'b0, 1'b0, 32'h0);
        do_update(32'h2100, 1'b1, 1'b0, 32'h900);
        do_lookup(32'h1100);
        total_cnt++;
        if (bp.pred_hit !== 1'b1 || bp.pred_tgt !== 32'h500)
            $display("FAIL miss_nowrite: got hit=%b tgt=%h want hit=1 tgt=500",
                     bp.pred_hit, bp.pred_tgt);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        bp.lk_en        = 1'b1;
        bp.lk_pc        = 32'h100;
        bp.up_valid     = 1'b1;
        bp.up_pc        = 32'h100;
        bp.up_is_branch = 1'b1;
        bp.up_taken     = 1'b1;
        bp.up_tgt       = 32'h240;
        cyc();
        bp.up_valid = 1'b0;
        total_cnt++;
        if (bp.pred_hit !== 1'b0) $display("FAIL rbw_hit: got %b want 0", bp.pred_hit);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h104) $display("FAIL rbw_tgt: got %h want 104", bp.pred_tgt);
        else pass_cnt++;
        cyc();
        bp.lk_en = 1'b0;
        total_cnt++;
        if (bp.pred_hit !== 1'b1) $display("FAIL after_rbw_hit: got %b want 1", bp.pred_hit);
        else pass_cnt++;
        total_cnt++;
        if (bp.pred_tgt !== 32'h240) $display("FAIL after_rbw_tgt: got %h want 240", bp.pred_tgt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_update(32'h10C, 1'b1, 1'b1, 32'h1000);
        do_update(32'h110, 1'b1, 1'b1, 32'h2000);
        bp.lk_en = 1'b1;
        bp.lk_pc = 32'h10C;
        cyc();
        bp.lk_pc = 32'h110;
        total_cnt++;
        if (bp.pred_hit !== 1'b1 || bp.pred_tgt !== 32'h1000)
            $display("FAIL b2b_a: got hit=%b tgt=%h want hit=1 tgt=1000",
                     bp.pred_hit, bp.pred_tgt);
        else pass_cnt++;
        cyc();
        bp.lk_pc = 32'hFFFF_FFFC;
        total_cnt++;
        if (bp.pred_hit !== 1'b1 || bp.pred_tgt !== 32'h2000)
            $display("FAIL b2b_b: got hit=%b tgt=%h want hit=1 tgt=2000",
                     bp.pred_hit, bp.pred_tgt);
        else pass_cnt++;
        cyc();
        bp.lk_en = 1'b0;
        bp.lk_pc = 32'h10C;
        total_cnt++;
        if (bp.pred_hit !== 1'b0 || bp.pred_tgt !== 32'h0)
            $display("FAIL pc_wrap: got hit=%b tgt=%h want hit=0 tgt=0",
                     bp.pred_hit, bp.pred_tgt);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (bp.pred_hit !== 1'b0 || bp.pred_tgt !== 32'h0)
            $display("FAIL lk_hold: got hit=%b tgt=%h want hit=0 tgt=0",
                     bp.pred_hit, bp.pred_tgt);
        else pass_cnt++;
    endtask

    task automatic test_mid_clear_reset();
        int n;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        total_cnt++;
        if (bp.busy !== 1'b1) $display("FAIL busy_mid: got %b want 1", bp.busy);
        else pass_cnt++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n = 0;
        bp.up_pc        = 32'h118;
        bp.up_is_branch = 1'b1;
        bp.up_taken     = 1'b1;
        bp.up_tgt       = 32'h3000;
        while (bp.busy === 1'b1 && n < 40) begin
            n++;
            bp.up_valid = (n >= 8);
            cyc();
        end
        bp.up_valid = 1'b0;
        total_cnt++;
        if (n != 16) $display("FAIL reclear_len: got %0d want 16", n);
        else pass_cnt++;
        do_lookup(32'h10C);
        total_cnt++;
        if (bp.pred_hit !== 1'b0) $display("FAIL stale_10c: got %b want 0", bp.pred_hit);
        else pass_cnt++;
        do_lookup(32'h100);
        total_cnt++;
        if (bp.pred_hit !== 1'b0) $display("FAIL stale_100: got %b want 0", bp.pred_hit);
        else pass_cnt++;
        do_lookup(32'h118);
        total_cnt++;
        if (bp.pred_hit !== 1'b0) $display("FAIL busy_update: got %b want 0", bp.pred_hit);
        else pass_cnt++;
    endtask

    initial begin
        rst             = 1'b1;
        bp.lk_en        = 1'b0;
        bp.lk_pc        = '0;
        bp.up_valid     = 1'b0;
        bp.up_pc        = '0;
        bp.up_is_branch = 1'b0;
        bp.up_taken     = 1'b0;
        bp.up_tgt       = '0;
        @(negedge clk);
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_same_cycle();
        test_back_to_back();
        test_mid_clear_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
